// File: rtl/go_pkg.sv
// Shared definitions for the 9x9 board move-entry logic.
// Board size, empty/pass encodings, entry FSM states, wrap helper.
package go_pkg;

    localparam int         BOARD_DIM = 9;
    localparam logic [1:0] EMPTY     = 2'b00;
    localparam logic [7:0] PASS_MOVE = 8'hFF;
    localparam logic [3:0] START_POS = 4'd4;

    typedef enum logic [1:0] {
        ST_LOCKED,
        ST_EDIT,
        ST_COMMIT,
        ST_HOLD
    } entry_state_t;

    // One step along an axis; dir=1 increments, dir=0 decrements, 0<->8 wraps.
    function automatic logic [3:0] wrap_step(
        input logic [3:0] pos,
        input logic       dir
    );
        logic [3:0] last;
        last = 4'(BOARD_DIM - 1);
        if (dir)
            wrap_step = (pos == last) ? 4'd0 : pos + 4'd1;
        else
            wrap_step = (pos == 4'd0) ? last : pos - 4'd1;
    endfunction

endpackage

// File: rtl/move_entry_dir_repeat.sv
// Per-direction button edge detector with optional auto-repeat.
// AUTO_REPEAT_EN adds a held-time counter that emits repeat steps.
module dir_repeat
    import go_pkg::*;
`ifdef AUTO_REPEAT_EN
#(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 6_500_000
)
`endif
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    input  logic i_en,
    output logic o_step
);

    logic r_prev;
    logic w_edge;

    assign w_edge = i_btn & ~r_prev;

    // Previous button sample for rising-edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_prev <= 1'b0;
        else
            r_prev <= i_btn;
    end

`ifdef AUTO_REPEAT_EN
    localparam int            CW        = $clog2(REPEAT_DELAY + 1);
    localparam logic [CW-1:0] DELAY_MAX = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RELOAD    = CW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    logic [CW-1:0] r_cnt;
    logic          w_rpt;

    assign w_rpt  = i_en & i_btn & ~w_edge & (r_cnt == DELAY_MAX);
    assign o_step = i_en & (w_edge | w_rpt);

    // Held-time counter; restarts on release or outside edit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (!i_en || !i_btn)
            r_cnt <= '0;
        else if (w_edge)
            r_cnt <= CW'(1);
        else if (w_rpt)
            r_cnt <= RELOAD;
        else
            r_cnt <= r_cnt + 1'b1;
    end
`else
    assign o_step = i_en & w_edge;
`endif

endmodule

// File: rtl/move_entry.sv
// Cursor-driven move entry: buttons -> cursor, commit pulse, reject.
// AUTO_REPEAT_EN enables auto-repeat on held direction buttons.
module move_entry
    import go_pkg::*;
#(
    parameter int HOLD_CYCLES   = 4,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 6_500_000
) (
    input  logic                                      clk_in,
    input  logic                                      reset,
    input  logic                                      my_turn,
    input  logic                                      btn_up,
    input  logic                                      btn_down,
    input  logic                                      btn_left,
    input  logic                                      btn_right,
    input  logic                                      btn_select,
    input  logic                                      btn_pass,
    input  logic [BOARD_DIM-1:0][BOARD_DIM-1:0][1:0] board,
    output logic [7:0]                                move_sel,
    output logic                                      make_move,
    output logic                                      reject
);

    localparam int             HCW       = $clog2(HOLD_CYCLES);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 2);

    if (HOLD_CYCLES < 3 || REPEAT_PERIOD < 1 ||
        REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_cfg
        $error("move_entry: invalid parameters");
    end

    entry_state_t   r_state, w_state_nxt;
    logic [3:0]     r_row, r_col, w_row_nxt, w_col_nxt;
    logic [7:0]     r_sel, w_sel_nxt;
    logic           r_make, w_make_nxt;
    logic           r_reject, w_reject_nxt;
    logic [HCW-1:0] r_hold, w_hold_nxt;
    logic           r_sel_prev, r_pass_prev;

    logic w_edit;
    logic w_up, w_down, w_left, w_right;
    logic w_sel_edge, w_pass_edge;
    logic w_occupied;

    assign w_edit      = (r_state == ST_EDIT);
    assign w_sel_edge  = btn_select & ~r_sel_prev;
    assign w_pass_edge = btn_pass & ~r_pass_prev;
    assign w_occupied  = (board[r_row][r_col] != EMPTY);

`ifdef AUTO_REPEAT_EN
    dir_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_up (
`else
    dir_repeat u_up (
`endif
        .i_clk (clk_in),
        .i_rst (reset),
        .i_btn (btn_up),
        .i_en  (w_edit),
        .o_step(w_up)
    );

`ifdef AUTO_REPEAT_EN
    dir_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_down (
`else
    dir_repeat u_down (
`endif
        .i_clk (clk_in),
        .i_rst (reset),
        .i_btn (btn_down),
        .i_en  (w_edit),
        .o_step(w_down)
    );

`ifdef AUTO_REPEAT_EN
    dir_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_left (
`else
    dir_repeat u_left (
`endif
        .i_clk (clk_in),
        .i_rst (reset),
        .i_btn (btn_left),
        .i_en  (w_edit),
        .o_step(w_left)
    );

`ifdef AUTO_REPEAT_EN
    dir_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_right (
`else
    dir_repeat u_right (
`endif
        .i_clk (clk_in),
        .i_rst (reset),
        .i_btn (btn_right),
        .i_en  (w_edit),
        .o_step(w_right)
    );

    // State, cursor, registered outputs and select/pass edge samples.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state     <= ST_LOCKED;
            r_row       <= START_POS;
            r_col       <= START_POS;
            r_sel       <= {START_POS, START_POS};
            r_make      <= 1'b0;
            r_reject    <= 1'b0;
            r_hold      <= '0;
            r_sel_prev  <= 1'b0;
            r_pass_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_sel       <= w_sel_nxt;
            r_make      <= w_make_nxt;
            r_reject    <= w_reject_nxt;
            r_hold      <= w_hold_nxt;
            r_sel_prev  <= btn_select;
            r_pass_prev <= btn_pass;
        end
    end

    // Next state, cursor movement, commit/reject decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_row_nxt    = r_row;
        w_col_nxt    = r_col;
        w_sel_nxt    = r_sel;
        w_make_nxt   = 1'b0;
        w_reject_nxt = 1'b0;
        w_hold_nxt   = r_hold;
        unique case (r_state)
            ST_LOCKED: begin
                if (my_turn)
                    w_state_nxt = ST_EDIT;
            end
            ST_EDIT: begin
                if (!my_turn) begin
                    w_state_nxt = ST_LOCKED;
                end else if (w_pass_edge) begin
                    w_state_nxt = ST_COMMIT;
                    w_make_nxt  = 1'b1;
                    w_sel_nxt   = PASS_MOVE;
                end else if (w_sel_edge) begin
                    if (w_occupied) begin
                        w_reject_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_COMMIT;
                        w_make_nxt  = 1'b1;
                    end
                end else begin
                    if (w_up && !w_down)
                        w_row_nxt = wrap_step(r_row, 1'b0);
                    else if (w_down && !w_up)
                        w_row_nxt = wrap_step(r_row, 1'b1);
                    if (w_left && !w_right)
                        w_col_nxt = wrap_step(r_col, 1'b0);
                    else if (w_right && !w_left)
                        w_col_nxt = wrap_step(r_col, 1'b1);
                    w_sel_nxt = {w_row_nxt, w_col_nxt};
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_HOLD;
                w_hold_nxt  = HOLD_LAST;
            end
            ST_HOLD: begin
                if (r_hold == '0) begin
                    w_state_nxt = my_turn ? ST_EDIT : ST_LOCKED;
                    w_sel_nxt   = {r_row, r_col};
                end else begin
                    w_hold_nxt = r_hold - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_LOCKED;
            end
        endcase
    end

    assign move_sel  = r_sel;
    assign make_move = r_make;
    assign reject    = r_reject;

endmodule

// File: tb/tb_move_entry.sv
// Self-checking bench for move_entry against a cursor/board model.
// Covers reset, movement, wrap, cancel, commit, reject, pass, repeat.
module tb_move_entry;

    logic clk_in     = 1'b0;
    logic reset      = 1'b0;
    logic my_turn    = 1'b0;
    logic btn_up     = 1'b0;
    logic btn_down   = 1'b0;
    logic btn_left   = 1'b0;
    logic btn_right  = 1'b0;
    logic btn_select = 1'b0;
    logic btn_pass   = 1'b0;
    logic [8:0][8:0][1:0] board = '0;
    logic [7:0] move_sel;
    logic       make_move;
    logic       reject;

    int checks = 0;
    int errors = 0;
    int m_row  = 4;
    int m_col  = 4;

    localparam logic [5:0] UP = 6'd1;
    localparam logic [5:0] DN = 6'd2;
    localparam logic [5:0] LF = 6'd4;
    localparam logic [5:0] RT = 6'd8;
    localparam logic [5:0] SL = 6'd16;
    localparam logic [5:0] PS = 6'd32;

    logic [5:0] mv_m [28] = '{
        RT, RT, LF, LF, UP, UP, UP, UP, UP, DN,
        UP | DN, LF | RT, UP | DN | RT, DN | LF,
        DN, DN, DN, RT, RT, RT, RT, RT,
        LF, LF, LF, LF, LF, UP | DN | LF | RT
    };
    logic [7:0] mv_e [28] = '{
        8'h45, 8'h46, 8'h45, 8'h44, 8'h34, 8'h24, 8'h14, 8'h04, 8'h84, 8'h04,
        8'h04, 8'h04, 8'h05, 8'h14,
        8'h24, 8'h34, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h40,
        8'h48, 8'h47, 8'h46, 8'h45, 8'h44, 8'h44
    };

    move_entry #(
        .HOLD_CYCLES  (4),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .my_turn   (my_turn),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_select(btn_select),
        .btn_pass  (btn_pass),
        .board     (board),
        .move_sel  (move_sel),
        .make_move (make_move),
        .reject    (reject)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [5:0] m);
        btn_up     = m[0];
        btn_down   = m[1];
        btn_left   = m[2];
        btn_right  = m[3];
        btn_select = m[4];
        btn_pass   = m[5];
    endtask

    function automatic int wrap9(input int p, input int d);
        return (p + d + 9) % 9;
    endfunction

    function automatic logic [7:0] cur();
        return 8'(m_row * 16 + m_col);
    endfunction

    function automatic void model_dirs(input logic [5:0] m);
        int dv;
        int dh;
        dv = 0;
        dh = 0;
        if (m[0] && !m[1]) dv = -1;
        if (m[1] && !m[0]) dv = 1;
        if (m[2] && !m[3]) dh = -1;
        if (m[3] && !m[2]) dh = 1;
        m_row = wrap9(m_row, dv);
        m_col = wrap9(m_col, dh);
    endfunction

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (move_sel !== 8'h44) begin
            errors++;
            $display("FAIL reset_sel got %h want 44", move_sel);
        end
        checks++;
        if (make_move !== 1'b0) begin
            errors++;
            $display("FAIL reset_make got %b want 0", make_move);
        end
        checks++;
        if (reject !== 1'b0) begin
            errors++;
            $display("FAIL reset_reject got %b want 0", reject);
        end
        my_turn = 1'b1;
        drive(RT | SL);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (move_sel !== 8'h44 || make_move !== 1'b0 || reject !== 1'b0) begin
                errors++;
                $display("FAIL held_thru_reset cyc %0d got sel %h mk %b rj %b want 44 0 0",
                         i, move_sel, make_move, reject);
            end
        end
        drive('0);
        tick();
    endtask

    task automatic test_move();
        for (int i = 0; i < 28; i++) begin
            drive(mv_m[i]);
            tick();
            checks++;
            if (move_sel !== mv_e[i] || make_move !== 1'b0) begin
                errors++;
                $display("FAIL move step %0d got sel %h mk %b want %h 0",
                         i, move_sel, make_move, mv_e[i]);
            end
            drive('0);
            tick();
        end
        m_row = 4;
        m_col = 4;
    endtask

    task automatic test_select();
        int pulses;
        pulses = 0;
        drive(SL);
        tick();
        pulses += int'(make_move);
        checks++;
        if (move_sel !== 8'h44 || make_move !== 1'b1) begin
            errors++;
            $display("FAIL select_commit got sel %h mk %b want 44 1", move_sel, make_move);
        end
        drive(RT);
        for (int k = 2; k <= 4; k++) begin
            tick();
            drive('0);
            pulses += int'(make_move);
            checks++;
            if (move_sel !== 8'h44) begin
                errors++;
                $display("FAIL select_hold n+%0d got %h want 44", k, move_sel);
            end
        end
        tick();
        pulses += int'(make_move);
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL select_pulses got %0d want 1", pulses);
        end
        drive(RT);
        tick();
        checks++;
        if (move_sel !== 8'h45) begin
            errors++;
            $display("FAIL select_exit_edit got %h want 45", move_sel);
        end
        drive('0);
        tick();
        drive(LF);
        tick();
        drive('0);
        tick();
    endtask

    task automatic test_reject();
        board[4][4] = 2'b01;
        drive(SL);
        tick();
        checks++;
        if (reject !== 1'b1 || make_move !== 1'b0 || move_sel !== 8'h44) begin
            errors++;
            $display("FAIL reject_pulse got rj %b mk %b sel %h want 1 0 44",
                     reject, make_move, move_sel);
        end
        drive('0);
        tick();
        checks++;
        if (reject !== 1'b0 || make_move !== 1'b0) begin
            errors++;
            $display("FAIL reject_single got rj %b mk %b want 0 0", reject, make_move);
        end
        drive(RT);
        tick();
        checks++;
        if (move_sel !== 8'h45) begin
            errors++;
            $display("FAIL reject_stays_edit got %h want 45", move_sel);
        end
        drive('0);
        tick();
        drive(LF);
        tick();
        drive('0);
        tick();
        board = '0;
    endtask

    task automatic test_pass();
        drive(PS | SL);
        tick();
        checks++;
        if (move_sel !== 8'hFF || make_move !== 1'b1) begin
            errors++;
            $display("FAIL pass_commit got sel %h mk %b want ff 1", move_sel, make_move);
        end
        drive('0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            if (k == 2) my_turn = 1'b0;
            checks++;
            if (move_sel !== 8'hFF || make_move !== 1'b0) begin
                errors++;
                $display("FAIL pass_hold n+%0d got sel %h mk %b want ff 0",
                         k, move_sel, make_move);
            end
        end
        tick();
        checks++;
        if (move_sel !== 8'h44 || make_move !== 1'b0) begin
            errors++;
            $display("FAIL pass_exit got sel %h mk %b want 44 0", move_sel, make_move);
        end
        drive(RT | SL);
        tick();
        drive('0);
        tick();
        checks++;
        if (move_sel !== 8'h44 || make_move !== 1'b0) begin
            errors++;
            $display("FAIL locked_ignores got sel %h mk %b want 44 0", move_sel, make_move);
        end
        my_turn = 1'b1;
        tick();
        drive(RT);
        tick();
        checks++;
        if (move_sel !== 8'h45) begin
            errors++;
            $display("FAIL unlock_edit got %h want 45", move_sel);
        end
        drive('0);
        tick();
        drive(LF);
        tick();
        drive('0);
        tick();
    endtask

    task automatic test_repeat();
        int steps;
        int col;
        drive(RT);
        for (int k = 1; k <= 20; k++) begin
            tick();
`ifdef AUTO_REPEAT_EN
            steps = 1 + ((k >= 11) ? 1 + (k - 11) / 3 : 0);
`else
            steps = 1;
`endif
            col = (4 + steps) % 9;
            checks++;
            if (move_sel !== 8'(64 + col)) begin
                errors++;
                $display("FAIL repeat edge+%0d got %h want %h", k, move_sel, 8'(64 + col));
            end
        end
        drive('0);
        tick();
        m_col = (4 + steps) % 9;
    endtask

    task automatic test_reset_mid();
        board = '0;
        drive(UP | LF);
        tick();
        model_dirs(UP | LF);
        drive('0);
        tick();
        drive(SL);
        tick();
        checks++;
        if (move_sel !== cur() || make_move !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_commit got sel %h mk %b want %h 1",
                     move_sel, make_move, cur());
        end
        drive('0);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (move_sel !== 8'h44 || make_move !== 1'b0 || reject !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_commit got sel %h mk %b rj %b want 44 0 0",
                     move_sel, make_move, reject);
        end
        tick();
        reset = 1'b0;
        m_row = 4;
        m_col = 4;
        tick();
        tick();
        drive(PS);
        tick();
        drive('0);
        tick();
        checks++;
        if (move_sel !== 8'hFF) begin
            errors++;
            $display("FAIL pre_reset_hold got %h want ff", move_sel);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (move_sel !== 8'h44 || make_move !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_hold got sel %h mk %b want 44 0", move_sel, make_move);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (move_sel !== 8'h44 || make_move !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet cyc %0d got sel %h mk %b want 44 0",
                         i, move_sel, make_move);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            logic [5:0] m;
            logic [7:0] exp_sel;
            logic       exp_mk;
            logic       exp_rj;
            bit         commit;
            m = 6'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0, 1:    m[4] = 1'b1;
                2:       m[5] = 1'b1;
                default: ;
            endcase
            if (m[4])
                board[m_row][m_col] = ($urandom_range(0, 1) == 0) ? 2'b00
                                      : 2'($urandom_range(1, 3));
            commit = 1'b0;
            exp_mk = 1'b0;
            exp_rj = 1'b0;
            drive(m);
            tick();
            if (m[5]) begin
                exp_sel = 8'hFF;
                exp_mk  = 1'b1;
                commit  = 1'b1;
            end else if (m[4]) begin
                exp_sel = cur();
                if (board[m_row][m_col] != 2'b00) begin
                    exp_rj = 1'b1;
                end else begin
                    exp_mk = 1'b1;
                    commit = 1'b1;
                end
            end else begin
                model_dirs(m);
                exp_sel = cur();
            end
            checks++;
            if ({move_sel, make_move, reject} !== {exp_sel, exp_mk, exp_rj}) begin
                errors++;
                $display("FAIL rand %0d btn %b got %h %b %b want %h %b %b",
                         it, m, move_sel, make_move, reject, exp_sel, exp_mk, exp_rj);
            end
            drive(commit ? 6'($urandom_range(0, 15)) : 6'd0);
            tick();
            drive('0);
            checks++;
            if (move_sel !== exp_sel || make_move !== 1'b0 || reject !== 1'b0) begin
                errors++;
                $display("FAIL rand_next %0d got %h %b %b want %h 0 0",
                         it, move_sel, make_move, reject, exp_sel);
            end
            if (commit) begin
                tick();
                tick();
                checks++;
                if (move_sel !== exp_sel) begin
                    errors++;
                    $display("FAIL rand_hold %0d got %h want %h", it, move_sel, exp_sel);
                end
                tick();
                checks++;
                if (move_sel !== cur() || make_move !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_exit %0d got %h %b want %h 0",
                             it, move_sel, make_move, cur());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_select();
        test_reject();
        test_pass();
        test_repeat();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
